// File: rtl/fp_mult_result_queue.sv
// Credit-based in-order result queue behind the never-stalling FP multiplier.
// Issue is granted only when a slot is reserved; results return via Valid/Ack.
module fp_mult_result_queue #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned FP_WIDTH   = 32,
   parameter int unsigned TAG_WIDTH  = 2,
   parameter int unsigned STAT_WIDTH = 5
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     IssueReq_i,
   output logic                     IssueGnt_o,
   output logic                     UnitEn_o,
   input  logic                     UnitValid_i,
   input  logic [FP_WIDTH-1:0]      UnitRes_i,
   input  logic [TAG_WIDTH-1:0]     UnitTag_i,
   input  logic [STAT_WIDTH-1:0]    UnitStatus_i,
   output logic                     Valid_o,
   output logic [FP_WIDTH-1:0]      Res_o,
   output logic [TAG_WIDTH-1:0]     Tag_o,
   output logic [STAT_WIDTH-1:0]    Status_o,
   input  logic                     Ack_i,
   output logic [$clog2(DEPTH):0]   Count_o,
   output logic                     Err_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned EW = FP_WIDTH + TAG_WIDTH + STAT_WIDTH;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW:0]   DEPTH_CX = (CW+1)'(DEPTH);

   logic [EW-1:0] mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CW-1:0] count_q, inflight_q;
   logic          err_q;

   logic [CW:0]   used;
   logic          full, valid, push, pop, inflight_dec, drop_err;
   logic [EW-1:0] head;

   // Credit check uses registered state only, so a same-cycle pop cannot free a slot.
   assign used       = {1'b0, count_q} + {1'b0, inflight_q};
   assign IssueGnt_o = (used < DEPTH_CX);
   assign UnitEn_o   = IssueReq_i & IssueGnt_o;

   assign full         = (count_q == DEPTH_C);
   assign valid        = (count_q != '0);
   assign inflight_dec = UnitValid_i & (inflight_q != '0);
   assign push         = inflight_dec & ~full;
   assign pop          = Ack_i & valid;
   assign drop_err     = UnitValid_i & ((inflight_q == '0) | full);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         inflight_q <= '0;
         err_q      <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         case ({UnitEn_o, inflight_dec})
            2'b10:   inflight_q <= inflight_q + CW'(1);
            2'b01:   inflight_q <= inflight_q - CW'(1);
            default: inflight_q <= inflight_q;
         endcase
         if (drop_err) err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= {UnitRes_i, UnitTag_i, UnitStatus_i};
   end

   assign head                     = mem_q[rd_ptr_q];
   assign Valid_o                  = valid;
   assign {Res_o, Tag_o, Status_o} = valid ? head : '0;
   assign Count_o                  = count_q;
   assign Err_o                    = err_q;

endmodule

// File: tb/tb_fp_mult_result_queue.sv
// Directed bench for fp_mult_result_queue with a 2-cycle multiplier stand-in.
module tb_fp_mult_result_queue;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        IssueReq_i, IssueGnt_o, UnitEn_o, UnitValid_i;
   logic [31:0] UnitRes_i;
   logic [1:0]  UnitTag_i;
   logic [4:0]  UnitStatus_i;
   logic        Valid_o;
   logic [31:0] Res_o;
   logic [1:0]  Tag_o;
   logic [4:0]  Status_o;
   logic        Ack_i;
   logic [2:0]  Count_o;
   logic        Err_o;

   int vectors = 0;
   int miscompares = 0;

   fp_mult_result_queue #(.DEPTH(4), .FP_WIDTH(32), .TAG_WIDTH(2), .STAT_WIDTH(5)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .IssueReq_i(IssueReq_i), .IssueGnt_o(IssueGnt_o), .UnitEn_o(UnitEn_o),
      .UnitValid_i(UnitValid_i), .UnitRes_i(UnitRes_i), .UnitTag_i(UnitTag_i),
      .UnitStatus_i(UnitStatus_i), .Valid_o(Valid_o), .Res_o(Res_o), .Tag_o(Tag_o),
      .Status_o(Status_o), .Ack_i(Ack_i), .Count_o(Count_o), .Err_o(Err_o)
   );

   always #5 clk_i = ~clk_i;

   // Multiplier stand-in: a grant at cycle k produces UnitValid at cycle k+2.
   logic        pv0, pv1, last_en;
   logic [31:0] pr0, pr1, last_res;
   logic [1:0]  pt0, pt1, last_tag;
   int          seq;
   logic        gnt_seen;

   always @(negedge clk_i) begin
      if (rst_ni === 1'b1) begin
         vectors++;
         if (dut.count_q + dut.inflight_q > 4) begin
            miscompares++;
            $display("FAIL invariant: count+inflight=%0d required <=4",
                     dut.count_q + dut.inflight_q);
         end
      end
   end

   task automatic step(input logic req, input logic ack);
      @(negedge clk_i);
      pv1 = pv0; pr1 = pr0; pt1 = pt0;
      pv0 = last_en; pr0 = last_res; pt0 = last_tag;
      UnitValid_i  = pv1;
      UnitRes_i    = pv1 ? pr1 : 32'h0;
      UnitTag_i    = pv1 ? pt1 : 2'd0;
      UnitStatus_i = pv1 ? {3'b0, pt1} : 5'd0;
      IssueReq_i = req;
      Ack_i      = ack;
      #1;
      gnt_seen = IssueGnt_o;
      last_en  = UnitEn_o;
      if (last_en) begin
         last_tag = seq[1:0];
         last_res = 32'h4080_0000 + 32'(seq) - 32'd1;
         seq++;
      end
   endtask

   task automatic do_reset(input logic clear_pipe);
      @(negedge clk_i);
      rst_ni = 1'b0;
      IssueReq_i = 1'b0; Ack_i = 1'b0; UnitValid_i = 1'b0;
      UnitRes_i = '0; UnitTag_i = '0; UnitStatus_i = '0;
      if (clear_pipe) begin
         pv0 = 0; pv1 = 0; last_en = 0;
         pr0 = '0; pr1 = '0; last_res = '0; pt0 = '0; pt1 = '0; last_tag = '0;
      end
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic test_reset;
      do_reset(1'b1);
      #1;
      vectors++;
      if ({Valid_o, Count_o, Err_o, Res_o, Tag_o, Status_o} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: valid=%b count=%0d err=%b res=%h tag=%0d stat=%0d required all 0",
                  Valid_o, Count_o, Err_o, Res_o, Tag_o, Status_o);
      end
      vectors++;
      if (IssueGnt_o !== 1'b1) begin
         miscompares++; $display("FAIL reset_gnt: gnt=%b required 1", IssueGnt_o);
      end
   endtask

   task automatic test_single_op;
      do_reset(1'b1); seq = 1;
      step(1, 0);
      vectors++;
      if ({IssueGnt_o, UnitEn_o} !== 2'b11) begin
         miscompares++; $display("FAIL t1_grant: gnt/en=%b required 11", {IssueGnt_o, UnitEn_o});
      end
      step(0, 0);
      step(0, 0);
      vectors++;
      if (UnitValid_i !== 1'b1 || Valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL t1_no_bypass: unit_valid=%b valid_o=%b required 1/0", UnitValid_i, Valid_o);
      end
      step(0, 1);
      vectors++;
      if (Valid_o !== 1'b1 || Res_o !== 32'h4080_0000 || Tag_o !== 2'd1 ||
          Status_o !== 5'd1 || Count_o !== 3'd1) begin
         miscompares++;
         $display("FAIL t1_result: valid=%b res=%h tag=%0d stat=%0d count=%0d required 1 40800000 1 1 1",
                  Valid_o, Res_o, Tag_o, Status_o, Count_o);
      end
      step(0, 0);
      vectors++;
      if (Valid_o !== 1'b0 || Count_o !== 3'd0 || Res_o !== 32'h0 || Err_o !== 1'b0) begin
         miscompares++;
         $display("FAIL t1_popped: valid=%b count=%0d res=%h err=%b required 0 0 0 0",
                  Valid_o, Count_o, Res_o, Err_o);
      end
   endtask

   task automatic test_backpressure_and_credit;
      int grants;
      do_reset(1'b1); seq = 0; grants = 0;
      for (int i = 0; i < 10; i++) begin
         step(1, 0);
         if (last_en) grants++;
      end
      vectors++;
      if (grants != 4) begin
         miscompares++; $display("FAIL t2_grants: got=%0d required 4", grants);
      end
      vectors++;
      if (IssueGnt_o !== 1'b0 || Count_o !== 3'd4 || Err_o !== 1'b0) begin
         miscompares++;
         $display("FAIL t2_full: gnt=%b count=%0d err=%b required 0 4 0", IssueGnt_o, Count_o, Err_o);
      end
      vectors++;
      if (Tag_o !== 2'd0) begin
         miscompares++; $display("FAIL t2_head: tag=%0d required 0", Tag_o);
      end
      step(0, 1);
      vectors++;
      if (IssueGnt_o !== 1'b0) begin
         miscompares++; $display("FAIL t3_gnt_during_pop: gnt=%b required 0", IssueGnt_o);
      end
      step(0, 0);
      vectors++;
      if (IssueGnt_o !== 1'b1 || Count_o !== 3'd3 || Tag_o !== 2'd1) begin
         miscompares++;
         $display("FAIL t3_gnt_after_pop: gnt=%b count=%0d tag=%0d required 1 3 1",
                  IssueGnt_o, Count_o, Tag_o);
      end
   endtask

   task automatic test_streaming;
      int popped;
      do_reset(1'b1); seq = 0; popped = 0;
      for (int i = 0; i < 26; i++) begin
         step(i < 20, 1);
         vectors++;
         if (Count_o > 3'd1) begin
            miscompares++; $display("FAIL t4_count: cycle %0d count=%0d required <=1", i, Count_o);
         end
         if (Valid_o === 1'b1) begin
            vectors++;
            if (Tag_o !== popped[1:0] || Res_o !== 32'h4080_0000 + 32'(popped) - 32'd1) begin
               miscompares++;
               $display("FAIL t4_order: pop %0d tag=%0d res=%h required %0d %h", popped, Tag_o,
                        Res_o, popped[1:0], 32'h4080_0000 + 32'(popped) - 32'd1);
            end
            popped++;
         end
      end
      vectors++;
      if (popped != 20 || Err_o !== 1'b0) begin
         miscompares++; $display("FAIL t4_total: popped=%0d err=%b required 20 0", popped, Err_o);
      end
   endtask

   task automatic test_back_to_back;
      do_reset(1'b1); seq = 0;
      step(1, 0); step(1, 0); step(1, 0); step(0, 0);
      step(0, 1);
      vectors++;
      if (Count_o !== 3'd2 || Tag_o !== 2'd0 || UnitValid_i !== 1'b1) begin
         miscompares++;
         $display("FAIL t5_setup: count=%0d tag=%0d unit_valid=%b required 2 0 1",
                  Count_o, Tag_o, UnitValid_i);
      end
      step(0, 0);
      vectors++;
      if (Count_o !== 3'd2 || Tag_o !== 2'd1) begin
         miscompares++; $display("FAIL t5_push_pop: count=%0d tag=%0d required 2 1", Count_o, Tag_o);
      end
      step(0, 1);
      step(0, 1);
      vectors++;
      if (Count_o !== 3'd1 || Tag_o !== 2'd2) begin
         miscompares++; $display("FAIL t5_tail: count=%0d tag=%0d required 1 2", Count_o, Tag_o);
      end
      step(0, 0);
      vectors++;
      if (Count_o !== 3'd0 || Valid_o !== 1'b0) begin
         miscompares++; $display("FAIL t5_drain: count=%0d valid=%b required 0 0", Count_o, Valid_o);
      end
   endtask

   task automatic test_reset_mid_op;
      do_reset(1'b1); seq = 0;
      step(1, 0); step(1, 0);
      do_reset(1'b0);
      #1;
      vectors++;
      if (Err_o !== 1'b0 || Valid_o !== 1'b0) begin
         miscompares++; $display("FAIL t6_after_reset: err=%b valid=%b required 0 0", Err_o, Valid_o);
      end
      step(0, 0);
      step(0, 0);
      vectors++;
      if (UnitValid_i !== 1'b1 || Err_o !== 1'b1) begin
         miscompares++;
         $display("FAIL t6_err_set: unit_valid=%b err=%b required 1 1", UnitValid_i, Err_o);
      end
      step(0, 0);
      step(0, 1);
      vectors++;
      if (Err_o !== 1'b1 || Valid_o !== 1'b0 || Count_o !== 3'd0 || IssueGnt_o !== 1'b1) begin
         miscompares++;
         $display("FAIL t6_dropped: err=%b valid=%b count=%0d gnt=%b required 1 0 0 1",
                  Err_o, Valid_o, Count_o, IssueGnt_o);
      end
   endtask

   initial begin
      rst_ni = 1'b0;
      IssueReq_i = 1'b0; Ack_i = 1'b0; UnitValid_i = 1'b0;
      UnitRes_i = '0; UnitTag_i = '0; UnitStatus_i = '0;
      pv0 = 0; pv1 = 0; last_en = 0; seq = 0; gnt_seen = 0;
      pr0 = '0; pr1 = '0; last_res = '0; pt0 = '0; pt1 = '0; last_tag = '0;
      test_reset();
      test_single_op();
      test_backpressure_and_credit();
      test_streaming();
      test_back_to_back();
      test_reset_mid_op();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
